// File: rtl/comp_pkg.sv
// Shared definitions for the 16-bit magnitude comparator and its downstream monitors:
// relation encoding, default datapath width and flag decode helpers.
package comp_pkg;

    localparam int COMP_W = 16;

    typedef enum logic [1:0] {
        REL_UNK   = 2'd0,
        REL_LESS  = 2'd1,
        REL_EQ    = 2'd2,
        REL_GREAT = 2'd3
    } rel_t;

    // Number of sample classes that carry their own event counter (LESS, EQ, GREAT).
    localparam int REL_CLASSES = 3;

    typedef struct packed {
        logic great;
        logic less;
        logic equal;
    } flags_t;

    function automatic logic flags_legal(flags_t f);
        logic [1:0] ones;
        ones = 2'(f.great) + 2'(f.less) + 2'(f.equal);
        return (ones == 2'd1);
    endfunction

    function automatic rel_t flags_class(flags_t f);
        rel_t r;
        r = REL_UNK;
        if (f.great) begin
            r = REL_GREAT;
        end else if (f.less) begin
            r = REL_LESS;
        end else if (f.equal) begin
            r = REL_EQ;
        end
        return r;
    endfunction

    // Counter slot index 0/1/2 maps onto LESS/EQ/GREAT.
    function automatic rel_t class_of_index(int idx);
        logic [1:0] slot;
        slot = idx[1:0];
        return rel_t'(slot + 2'd1);
    endfunction

endpackage

// File: rtl/comp_crossing_monitor_if.sv
// Bus between the comparator-side driver and the crossing monitor.
// cross_cnt exists only when COMP_MON_CROSS_CNT_EN is defined.
interface comp_crossing_monitor_if
    import comp_pkg::*;
#(
    parameter int CNT_W = COMP_W
);
    logic             in_valid;
    logic             great;
    logic             less;
    logic             equal;
    logic             clr;
    rel_t             state;
    logic             rise;
    logic             fall;
    logic             err;
    logic [CNT_W-1:0] great_cnt;
    logic [CNT_W-1:0] less_cnt;
    logic [CNT_W-1:0] equal_cnt;
`ifdef COMP_MON_CROSS_CNT_EN
    logic [CNT_W-1:0] cross_cnt;

    modport master (
        output in_valid, great, less, equal, clr,
        input  state, rise, fall, err, great_cnt, less_cnt, equal_cnt, cross_cnt
    );

    modport slave (
        input  in_valid, great, less, equal, clr,
        output state, rise, fall, err, great_cnt, less_cnt, equal_cnt, cross_cnt
    );
`else
    modport master (
        output in_valid, great, less, equal, clr,
        input  state, rise, fall, err, great_cnt, less_cnt, equal_cnt
    );

    modport slave (
        input  in_valid, great, less, equal, clr,
        output state, rise, fall, err, great_cnt, less_cnt, equal_cnt
    );
`endif
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clr has priority over inc.
module sat_counter
    import comp_pkg::*;
#(
    parameter int CNT_W = COMP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             at_max;

    assign at_max = (cnt_reg == {CNT_W{1'b1}});

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && !at_max) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/comp_crossing_monitor.sv
// Debounces comparator flags into a confirmed relation, pulses on LESS<->GREAT crossings
// and keeps saturating event counters. COMP_MON_CROSS_CNT_EN adds the crossing counter.
module comp_crossing_monitor
    import comp_pkg::*;
#(
    parameter int PERSIST = 3,
    parameter int CNT_W   = COMP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    comp_crossing_monitor_if.slave mon
);

    localparam int               RUN_W       = 4;
    localparam logic [RUN_W-1:0] PERSIST_RUN = RUN_W'(PERSIST);

    flags_t           flags;
    logic             legal;
    rel_t             cls;
    logic             accept;

    rel_t             state_reg,     state_next;
    rel_t             cand_reg,      cand_next;
    rel_t             last_side_reg, last_side_next;
    logic [RUN_W-1:0] run_reg,       run_next;
    logic             rise_reg,      rise_next;
    logic             fall_reg,      fall_next;
    logic             err_reg,       err_next;
    logic             confirm;

    assign flags  = flags_t'({mon.great, mon.less, mon.equal});
    assign legal  = flags_legal(flags);
    assign cls    = flags_class(flags);
    assign accept = mon.in_valid && legal;

    // Streak tracking: an illegal sample breaks the streak, an idle cycle only holds it.
    always_comb begin
        cand_next = cand_reg;
        run_next  = run_reg;
        err_next  = 1'b0;
        if (mon.in_valid) begin
            if (!legal) begin
                err_next  = 1'b1;
                cand_next = REL_UNK;
                run_next  = '0;
            end else if (cls == cand_reg) begin
                if (run_reg < PERSIST_RUN) begin
                    run_next = run_reg + 1'b1;
                end
            end else begin
                cand_next = cls;
                run_next  = RUN_W'(1);
            end
        end
    end

    assign confirm = accept && (run_next == PERSIST_RUN) && (cand_next != state_reg);

    // last_side remembers the side we came from, so LESS->EQ->GREAT is still one rise.
    always_comb begin
        state_next     = state_reg;
        last_side_next = last_side_reg;
        rise_next      = 1'b0;
        fall_next      = 1'b0;
        if (confirm) begin
            state_next = cand_next;
            rise_next  = (cand_next == REL_GREAT) && (last_side_reg == REL_LESS);
            fall_next  = (cand_next == REL_LESS)  && (last_side_reg == REL_GREAT);
            if (cand_next != REL_EQ) begin
                last_side_next = cand_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= REL_UNK;
            cand_reg      <= REL_UNK;
            last_side_reg <= REL_UNK;
            run_reg       <= '0;
            rise_reg      <= 1'b0;
            fall_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            last_side_reg <= last_side_next;
            run_reg       <= run_next;
            rise_reg      <= rise_next;
            fall_reg      <= fall_next;
            err_reg       <= err_next;
        end
    end

    assign mon.state = state_reg;
    assign mon.rise  = rise_reg;
    assign mon.fall  = fall_reg;
    assign mon.err   = err_reg;

    logic [REL_CLASSES-1:0] class_hit;
    logic [CNT_W-1:0]       class_cnt [REL_CLASSES];

    generate
        for (genvar gi = 0; gi < REL_CLASSES; gi++) begin : g_class
            assign class_hit[gi] = accept && (cls == class_of_index(gi));

            sat_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (class_hit[gi]),
                .clr (mon.clr),
                .cnt (class_cnt[gi])
            );
        end
    endgenerate

    assign mon.less_cnt  = class_cnt[0];
    assign mon.equal_cnt = class_cnt[1];
    assign mon.great_cnt = class_cnt[2];

`ifdef COMP_MON_CROSS_CNT_EN
    // Counted on the pulse's own edge so cross_cnt and rise/fall move together.
    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cross_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rise_next | fall_next),
        .clr (mon.clr),
        .cnt (mon.cross_cnt)
    );
`endif

endmodule

// File: tb/tb_comp_crossing_monitor.sv
// Table-driven bench for comp_crossing_monitor (PERSIST=3) with an expected-result queue.
module tb_comp_crossing_monitor;
    import comp_pkg::*;

    localparam int         CNT_W = 16;
    localparam logic [2:0] FG    = 3'b100;
    localparam logic [2:0] FL    = 3'b010;
    localparam logic [2:0] FE    = 3'b001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    comp_crossing_monitor_if #(.CNT_W(CNT_W)) bus ();

    comp_crossing_monitor #(
        .PERSIST (3),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    typedef struct {
        logic       v;
        logic [2:0] f;
        logic       c;
        logic [1:0] st;
        logic       r;
        logic       fl;
        logic       e;
    } vec_t;

    typedef struct {
        string            tag;
        logic [1:0]       st;
        logic             r;
        logic             fl;
        logic             e;
        logic [CNT_W-1:0] gc;
        logic [CNT_W-1:0] lc;
        logic [CNT_W-1:0] ec;
        logic [CNT_W-1:0] xc;
    } exp_t;

    exp_t             sb[$];
    vec_t             tbl[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] m_gc, m_lc, m_ec, m_xc;

    function automatic vec_t mk(logic v, logic [2:0] f, logic c, logic [1:0] st,
                                logic r, logic fl, logic e);
        vec_t t;
        t.v = v; t.f = f; t.c = c; t.st = st; t.r = r; t.fl = fl; t.e = e;
        return t;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, what, act, req);
        end
    endtask

    task automatic push_exp(input string tag, input logic [1:0] st,
                            input logic r, input logic fl, input logic e);
        exp_t x;
        x.tag = tag; x.st = st; x.r = r; x.fl = fl; x.e = e;
        x.gc = m_gc; x.lc = m_lc; x.ec = m_ec; x.xc = m_xc;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        int   e0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard.empty actual=0 required=1");
            return;
        end
        x  = sb.pop_front();
        e0 = errors;
        chk(x.tag, "state", 32'(bus.state), 32'(x.st));
        chk(x.tag, "rise", 32'(bus.rise), 32'(x.r));
        chk(x.tag, "fall", 32'(bus.fall), 32'(x.fl));
        chk(x.tag, "err", 32'(bus.err), 32'(x.e));
        chk(x.tag, "great_cnt", 32'(bus.great_cnt), 32'(x.gc));
        chk(x.tag, "less_cnt", 32'(bus.less_cnt), 32'(x.lc));
        chk(x.tag, "equal_cnt", 32'(bus.equal_cnt), 32'(x.ec));
`ifdef COMP_MON_CROSS_CNT_EN
        chk(x.tag, "cross_cnt", 32'(bus.cross_cnt), 32'(x.xc));
`endif
        $display("txn %-10s state=%0d rise=%0b fall=%0b err=%0b g=%0h l=%0h e=%0h new_errors=%0d",
                 x.tag, bus.state, bus.rise, bus.fall, bus.err,
                 bus.great_cnt, bus.less_cnt, bus.equal_cnt, errors - e0);
    endtask

    // Drive one cycle, update the counter model, queue the expectation, check after the edge.
    task automatic step(input vec_t t, input string tag);
        bus.in_valid = t.v;
        {bus.great, bus.less, bus.equal} = t.f;
        bus.clr = t.c;
        if (t.c) begin
            m_gc = '0; m_lc = '0; m_ec = '0; m_xc = '0;
        end else begin
            if (t.v && t.f == FG) m_gc = sat_inc(m_gc);
            if (t.v && t.f == FL) m_lc = sat_inc(m_lc);
            if (t.v && t.f == FE) m_ec = sat_inc(m_ec);
            if (t.r || t.fl)      m_xc = sat_inc(m_xc);
        end
        push_exp(tag, t.st, t.r, t.fl, t.e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Asynchronous reset asserted just after an edge; outputs must clear before the next edge.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        m_gc = '0; m_lc = '0; m_ec = '0; m_xc = '0;
        push_exp(tag, 2'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.great    = 1'b0;
        bus.less     = 1'b0;
        bus.equal    = 1'b0;
        bus.clr      = 1'b0;
        m_gc = '0; m_lc = '0; m_ec = '0; m_xc = '0;

        //                  v   flags   clr  st  rise fall err
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd0, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd0, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd1, 0, 1, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd3, 1, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd1, 0, 1, 0));
        tbl.push_back(mk(1'b1, FE,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b1, FE,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b1, FE,     1'b0, 2'd2, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd2, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd2, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd3, 1, 0, 0));
        tbl.push_back(mk(1'b1, 3'b110, 1'b0, 2'd3, 0, 0, 1));
        tbl.push_back(mk(1'b0, 3'b110, 1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b0, FG,     1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, 3'b000, 1'b0, 2'd3, 0, 0, 1));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd1, 0, 1, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b0, FG,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b0, 3'b110, 1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd3, 1, 0, 0));
        tbl.push_back(mk(1'b0, 3'b000, 1'b1, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b1, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b1, 2'd3, 0, 0, 0));
        tbl.push_back(mk(1'b1, FL,     1'b0, 2'd1, 0, 1, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(1'b1, FG,     1'b0, 2'd3, 1, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        push_exp("reset", 2'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("row%0d", i));
        end

        // Reset while rise is high, then reset two samples into a GREAT streak.
        pulse_reset("rst_pulse");
        step(mk(1'b1, FG, 1'b0, 2'd0, 0, 0, 0), "pre_g1");
        step(mk(1'b1, FG, 1'b0, 2'd0, 0, 0, 0), "pre_g2");
        pulse_reset("rst_strk");
        step(mk(1'b1, FG, 1'b0, 2'd0, 0, 0, 0), "post_g1");
        step(mk(1'b1, FG, 1'b0, 2'd0, 0, 0, 0), "post_g2");
        step(mk(1'b1, FG, 1'b0, 2'd3, 0, 0, 0), "post_g3");

        // Bring great_cnt to 16'hFFFE with a long GREAT run, then saturate it.
        step(mk(1'b0, 3'b000, 1'b1, 2'd3, 0, 0, 0), "pre_clr");
        bus.in_valid = 1'b1;
        {bus.great, bus.less, bus.equal} = FG;
        bus.clr = 1'b0;
        m_gc = 16'hFFFE;
        push_exp("bulk", 2'd3, 1'b0, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        check_out();
        for (int k = 0; k < 3; k++) begin
            step(mk(1'b1, FG, 1'b0, 2'd3, 0, 0, 0), $sformatf("sat%0d", k));
        end
        step(mk(1'b1, FG, 1'b1, 2'd3, 0, 0, 0), "clr_g");
        // The streak survives clr: a LESS run still confirms on its third sample.
        step(mk(1'b1, FL, 1'b0, 2'd3, 0, 0, 0), "end_l1");
        step(mk(1'b1, FL, 1'b0, 2'd3, 0, 0, 0), "end_l2");
        step(mk(1'b1, FL, 1'b0, 2'd1, 0, 1, 0), "end_l3");

        bus.in_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
